// File: rtl/vector_datapath_pkg.sv
// Shared project definitions for the vector scanning datapath and its controller.
// Holds default geometry and the controller state encoding.
package vector_datapath_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int IDX_W_DEF = 3;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'b00,
        CTRL_BEGIN = 2'b01,
        CTRL_COUNT = 2'b10,
        CTRL_READY = 2'b11
    } ctrl_state_t;

endpackage

// File: rtl/vector_datapath_mod_counter.sv
// Modulo-WIDTH bit index counter with clear, increment and terminal-count flag.
// Reset has priority over clear, and clear has priority over increment.
module mod_counter
    import vector_datapath_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] q,
    output logic             tc
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

    logic [IDX_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= (r_q == LAST) ? '0 : r_q + 1'b1;
        end
    end

    assign q  = r_q;
    assign tc = (r_q == LAST);

endmodule

// File: rtl/vector_datapath.sv
// Bit-serial vector scanner: counts set bits and records the lowest set index
// under external controller strobes; results freeze once ready is seen.
module vector_datapath
    import vector_datapath_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             En,
    input  logic             inc_vector,
    input  logic             inc_counter,
    input  logic             ready,
    output logic             co,
    output logic [IDX_W:0]   ones,
    output logic [IDX_W-1:0] first_idx,
    output logic             found,
    output logic             valid
);

    logic [WIDTH-1:0] r_vec;
    logic [IDX_W:0]   r_ones;
    logic [IDX_W-1:0] r_first_idx;
    logic             r_found;
    logic             r_valid;
    logic [IDX_W-1:0] w_idx;
    logic             w_tc;
    logic             w_idx_inc;

    // Once results are final the index must freeze along with everything else.
    assign w_idx_inc = inc_counter & ~r_valid;

    mod_counter #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .inc (w_idx_inc),
        .q   (w_idx),
        .tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec       <= '0;
            r_ones      <= '0;
            r_first_idx <= '0;
            r_found     <= 1'b0;
            r_valid     <= 1'b0;
        end else if (start) begin
            r_vec       <= data_in;
            r_ones      <= '0;
            r_first_idx <= '0;
            r_found     <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            if (ready) begin
                r_valid <= 1'b1;
            end
            if (!r_valid) begin
                if (En && r_vec[0]) begin
                    r_ones <= r_ones + 1'b1;
                    if (!r_found) begin
                        r_first_idx <= w_idx;
                        r_found     <= 1'b1;
                    end
                end
                if (inc_vector) begin
                    r_vec <= {1'b0, r_vec[WIDTH-1:1]};
                end
            end
        end
    end

    assign co        = w_tc;
    assign ones      = r_ones;
    assign first_idx = r_first_idx;
    assign found     = r_found;
    assign valid     = r_valid;

endmodule

// File: tb/tb_vector_datapath.sv
// Self-checking bench for vector_datapath: directed scenarios plus random vectors,
// with expected {found, first_idx, ones} results queued at load time.
module tb_vector_datapath;

    localparam int W  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  data_in;
    logic          En;
    logic          inc_vector;
    logic          inc_counter;
    logic          ready;
    logic          co;
    logic [IW:0]   ones;
    logic [IW-1:0] first_idx;
    logic          found;
    logic          valid;

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    vector_datapath #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .En          (En),
        .inc_vector  (inc_vector),
        .inc_counter (inc_counter),
        .ready       (ready),
        .co          (co),
        .ones        (ones),
        .first_idx   (first_idx),
        .found       (found),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    // Reference: packed {found, first_idx[2:0], ones[3:0]} for a full scan of d.
    function automatic logic [W-1:0] model(input logic [W-1:0] d);
        logic [IW:0]   cnt = '0;
        logic [IW-1:0] fi  = '0;
        logic          fnd = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (d[i]) begin
                cnt = cnt + 1'b1;
                if (!fnd) begin
                    fi  = IW'(i);
                    fnd = 1'b1;
                end
            end
        end
        return {fnd, fi, cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic v);
        En = v; inc_vector = v; inc_counter = v;
    endtask

    task automatic drive_load(input logic [W-1:0] d);
        start = 1'b1; data_in = d;
        step();
        start = 1'b0;
    endtask

    task automatic drive_scan(input int cycles, output logic [W-1:0] co_seen);
        co_seen = '0;
        set_ctrl(1'b1);
        for (int c = 0; c < cycles; c++) begin
            co_seen[c] = co;
            step();
        end
        set_ctrl(1'b0);
    endtask

    task automatic drive_ready();
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; data_in = 8'hFF; set_ctrl(1'b1); ready = 1'b1;
        step(); step();
        start = 1'b0; set_ctrl(1'b0); ready = 1'b0;
        step();
        rst = 1'b0;
        n_tests++;
        if ({found, first_idx, ones} !== 8'h00) begin
            n_fail++; $display("FAIL reset_results got=%h exp=00", {found, first_idx, ones});
        end
        n_tests++;
        if (co !== 1'b0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_co_valid got co=%b valid=%b exp 0 0", co, valid);
        end
    endtask

    task automatic test_scan(input string name, input logic [W-1:0] d);
        logic [W-1:0] co_seen;
        logic [W-1:0] exp;
        exp_q.push_back(model(d));
        drive_load(d);
        drive_scan(W, co_seen);
        drive_ready();
        exp = exp_q.pop_front();
        n_tests++;
        if ({found, first_idx, ones} !== exp) begin
            n_fail++; $display("FAIL %s_result got=%h exp=%h", name, {found, first_idx, ones}, exp);
        end
        n_tests++;
        if (co_seen !== 8'h80) begin
            n_fail++; $display("FAIL %s_co_pattern got=%b exp=10000000", name, co_seen);
        end
        n_tests++;
        if (valid !== 1'b1 || co !== 1'b0) begin
            n_fail++; $display("FAIL %s_valid_wrap got valid=%b co=%b exp 1 0", name, valid, co);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [W-1:0] co_seen;
        drive_load(8'hFF);
        drive_scan(3, co_seen);
        rst = 1'b1; start = 1'b1; set_ctrl(1'b1);
        step();
        rst = 1'b0; start = 1'b0; set_ctrl(1'b0);
        n_tests++;
        if ({found, first_idx, ones} !== 8'h00 || co !== 1'b0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_clear got=%h co=%b valid=%b exp=00 0 0",
                               {found, first_idx, ones}, co, valid);
        end
        // Without a new start the cleared vector must yield nothing.
        drive_scan(W, co_seen);
        drive_ready();
        n_tests++;
        if ({found, first_idx, ones} !== 8'h00 || valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_nostart got=%h valid=%b exp=00 1", {found, first_idx, ones}, valid);
        end
        test_scan("midrst_restart", 8'hFF);
    endtask

    task automatic test_start_priority();
        logic [W-1:0] co_seen;
        drive_load(8'b0000_0011);
        drive_scan(2, co_seen);
        n_tests++;
        if (ones !== 4'd2 || found !== 1'b1) begin
            n_fail++; $display("FAIL prio_pre got ones=%0d found=%b exp 2 1", ones, found);
        end
        start = 1'b1; data_in = 8'hA4; set_ctrl(1'b1); ready = 1'b1;
        step();
        start = 1'b0; set_ctrl(1'b0); ready = 1'b0;
        n_tests++;
        if ({found, first_idx, ones} !== 8'h00 || co !== 1'b0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL prio_clear got=%h co=%b valid=%b exp=00 0 0",
                               {found, first_idx, ones}, co, valid);
        end
        // The loaded 8'hA4 must now be in the vector: popcount 3, lowest bit 2.
        exp_q.push_back(model(8'hA4));
        drive_scan(W, co_seen);
        drive_ready();
        n_tests++;
        if ({found, first_idx, ones} !== exp_q.pop_front() || co_seen !== 8'h80) begin
            n_fail++; $display("FAIL prio_scan got=%h co=%b exp=%h 10000000",
                               {found, first_idx, ones}, co_seen, model(8'hA4));
        end
    endtask

    task automatic test_hold_after_ready();
        logic [W-1:0] d;
        logic [W-1:0] exp;
        d = W'($urandom_range(1, 255));
        test_scan("hold_setup", d);
        exp = model(d);
        for (int i = 0; i < 20; i++) begin
            En          = 1'($urandom_range(0, 1));
            inc_vector  = 1'($urandom_range(0, 1));
            inc_counter = 1'($urandom_range(0, 1));
            ready       = 1'($urandom_range(0, 1));
            step();
            n_tests++;
            if ({found, first_idx, ones} !== exp || valid !== 1'b1 || co !== 1'b0) begin
                n_fail++; $display("FAIL hold_cycle%0d got=%h valid=%b co=%b exp=%h 1 0",
                                   i, {found, first_idx, ones}, valid, co, exp);
            end
        end
        set_ctrl(1'b0); ready = 1'b0;
    endtask

    task automatic test_idle_hold();
        logic [W-1:0] co_seen;
        drive_load(8'b0110_0100);
        drive_scan(3, co_seen);
        for (int i = 0; i < 4; i++) step();
        n_tests++;
        if ({found, first_idx, ones} !== {1'b1, 3'd2, 4'd1} || valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold got=%h valid=%b exp=a1 0", {found, first_idx, ones}, valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            test_scan("random", W'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_in = '0; ready = 1'b0;
        set_ctrl(1'b0);
        test_reset();
        test_scan("typical", 8'b1011_0010);
        test_scan("all_zeros", 8'h00);
        test_scan("all_ones", 8'hFF);
        test_reset_mid_scan();
        test_start_priority();
        test_hold_after_ready();
        test_idle_hold();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_datapath.md
VECTOR_DATAPATH -- requirements
Module: vector_datapath

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the processed vector width in bits (power of two, at least 2).
REQ-002 The block SHALL have parameter IDX_W, default 3, giving the index width, equal to log2(WIDTH).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
 clk  input  1  clock; all state changes on the rising edge
 rst  input  1  synchronous active-high reset
 start  input  1  load strobe from the controller side; loads data_in and clears counters
 data_in  input  WIDTH  vector to be scanned
 En  input  1  enables ones accumulation for the current bit
 inc_vector  input  1  shifts the vector right by one
 inc_counter  input  1  increments the bit index
 ready  input  1  controller-done indication; freezes the results
 co  output  1  carry-out: index at last bit
 ones  output  IDX_W+1  running or final count of 1 bits
 first_idx  output  IDX_W  index of the lowest set bit seen
 found  output  1  at least one set bit seen
 valid  output  1  results final and stable

Function
REQ-004 The block SHALL hold registers vec[WIDTH-1:0], idx[IDX_W-1:0], ones[IDX_W:0], first_idx, found, and valid.
REQ-005 co SHALL be combinational and SHALL equal (idx == WIDTH-1), independent of the control inputs.
REQ-006 When start=1 on a clock edge, the block SHALL load vec<=data_in and clear idx, ones, first_idx, found and valid to 0. start SHALL override En, inc_vector, inc_counter and ready on that edge.
REQ-007 When start=0, En=1 and vec[0]=1 on an edge, ones SHALL increment by 1; if found=0 on that edge, the block SHALL also set first_idx<=idx and found<=1.
REQ-008 When start=0 and inc_vector=1 on an edge, the block SHALL perform vec<={1'b0, vec[WIDTH-1:1]}.
REQ-009 When start=0 and inc_counter=1 on an edge, the block SHALL perform idx<=idx+1, wrapping modulo WIDTH (from WIDTH-1 to 0).
REQ-010 The three control inputs SHALL act independently; any combination of them on one edge SHALL apply all of the selected updates, each evaluated on pre-edge values.
REQ-011 With En, inc_vector and inc_counter asserted together for exactly WIDTH consecutive cycles after a load, the block SHALL leave ones equal to popcount(data_in); the cycle in which co=1 SHALL be the last bit processed.
REQ-012 When ready=1 and start=0 on an edge, the block SHALL set valid<=1. While valid=1, the block SHALL ignore En, inc_vector and inc_counter and SHALL hold all results until the next start or rst.
REQ-013 ones SHALL never overflow: its maximum value is WIDTH, which fits in IDX_W+1 bits.
REQ-014 With the control inputs idle (all 0, no start), the block SHALL hold all registers.
REQ-015 There SHALL be no latency beyond one edge: every update SHALL be visible on the outputs in the cycle after the edge that causes it.

Reset
REQ-016 When rst=1 on an edge, the block SHALL clear vec, idx, ones, first_idx, found and valid to 0, overriding all other inputs, including start.
REQ-017 After reset, co SHALL read 0 (idx=0) for WIDTH>1.
REQ-018 When rst is applied mid-scan, the block SHALL discard the partial results; the next scan SHALL require a new start.

Structure
REQ-019 WIDTH and IDX_W default values SHALL live in the shared project package, together with the controller state encoding (Idle/Begin/Count/Ready = 2'b00/01/10/11).
REQ-020 The index SHALL be implemented as one sub-module, mod_counter, with ports clk, rst, clr, inc, q and tc (terminal count). co SHALL be driven from tc.
REQ-021 The block SHALL be instantiated alongside the controller, with controller En/inc_vector/inc_counter/ready driving the same-named inputs and co feeding back to the controller.

Verification
REQ-022 Scenario "typical vector": WIDTH=8; start with data_in=8'b1011_0010, then 8 cycles with all three controls =1, then ready -> ones=4, first_idx=1, found=1, valid=1, co=1 in the 8th cycle only.
REQ-023 Scenario "all zeros": data_in=8'h00, full scan -> ones=0, found=0, first_idx=0.
REQ-024 Scenario "all ones": data_in=8'hFF, full scan -> ones=8 (4'b1000), first_idx=0; idx wraps to 0 after the 8th increment.
REQ-025 Scenario "reset mid-scan": rst=1 after 3 scan cycles of 8'hFF -> next cycle ones=0, idx=0, valid=0; a subsequent start then restarts cleanly.
REQ-026 Scenario "start priority": start=1 together with En=1 and inc_counter=1 while ones=2 -> ones=0, idx=0, vec=data_in.
REQ-027 Scenario "hold after ready": En, inc_vector and inc_counter toggled randomly after valid=1 -> outputs unchanged.
